// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame controller.
package uart_frame_pkg;

    typedef enum logic [1:0] {
        HUNT,
        PAYLOAD,
        CSUM,
        HOLD
    } frame_state_t;

    localparam logic [1:0] ERR_OVERRUN = 2'd0;
    localparam logic [1:0] ERR_PARITY  = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hAA;
    localparam int unsigned PAYLOAD_LEN       = 4;

endpackage

// File: rtl/frame_timeout_timer.sv
// Inter-byte timeout counter; expires on its terminal cycle unless a byte restarts it.
module frame_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic restart,
    output logic expired
);

    localparam int unsigned   TW   = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_count;

    // Held at zero while idle, so a frame always starts counting from a clean value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (!run || restart) begin
            r_count <= '0;
        end else if (r_count != LAST) begin
            r_count <= r_count + TW'(1);
        end
    end

    assign expired = run && !restart && (r_count == LAST);

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame controller: hunts a sync byte, collects payload plus XOR checksum and
// hands good frames to the consumer over valid/ready, reporting framing errors.
module uart_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_perr,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic [31:0] frame_data,
    output logic        err_pulse,
    output logic [1:0]  err_code,
    output logic [7:0]  frame_cnt,
    output logic [7:0]  err_cnt
);

    localparam int unsigned   IW       = $clog2(PAYLOAD_LEN);
    localparam logic [IW-1:0] LAST_IDX = IW'(PAYLOAD_LEN - 1);

    frame_state_t  r_state;
    logic [IW-1:0] r_idx;
    logic [7:0]    r_xor;

    logic       w_run;
    logic       w_expired;
    logic       w_sync;
    logic       w_xfer;
    logic       w_err;
    logic [1:0] w_err_code;

    assign w_run  = (r_state == PAYLOAD) || (r_state == CSUM);
    assign w_sync = rx_valid && !rx_perr && (rx_data == SYNC_BYTE);
    assign w_xfer = frame_valid && frame_ready;

    frame_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (w_run),
        .restart(rx_valid),
        .expired(w_expired)
    );

    always_comb begin
        w_err      = 1'b0;
        w_err_code = ERR_OVERRUN;
        unique case (r_state)
            PAYLOAD, CSUM: begin
                if (rx_valid && rx_perr) begin
                    w_err      = 1'b1;
                    w_err_code = ERR_PARITY;
                end else if (rx_valid && (r_state == CSUM) && (rx_data != r_xor)) begin
                    w_err      = 1'b1;
                    w_err_code = ERR_CSUM;
                end else if (w_expired) begin
                    w_err      = 1'b1;
                    w_err_code = ERR_TIMEOUT;
                end
            end
            HOLD: begin
                if (rx_valid && !frame_ready) begin
                    w_err      = 1'b1;
                    w_err_code = ERR_OVERRUN;
                end
            end
            default: ;
        endcase
    end

    // frame_data doubles as the payload assembly register; it only changes outside HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= HUNT;
            r_idx       <= '0;
            r_xor       <= '0;
            frame_valid <= 1'b0;
            frame_data  <= '0;
            err_pulse   <= 1'b0;
            err_code    <= '0;
            frame_cnt   <= '0;
            err_cnt     <= '0;
        end else begin
            err_pulse <= w_err;
            if (w_err) begin
                err_code <= w_err_code;
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end

            unique case (r_state)
                HUNT: begin
                    if (w_sync) begin
                        r_state <= PAYLOAD;
                        r_idx   <= '0;
                        r_xor   <= '0;
                    end
                end
                PAYLOAD: begin
                    if (w_err) begin
                        r_state <= HUNT;
                    end else if (rx_valid) begin
                        frame_data[{r_idx, 3'b000} +: 8] <= rx_data;
                        r_xor <= r_xor ^ rx_data;
                        r_idx <= r_idx + IW'(1);
                        if (r_idx == LAST_IDX) begin
                            r_state <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (w_err) begin
                        r_state <= HUNT;
                    end else if (rx_valid) begin
                        r_state     <= HOLD;
                        frame_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    // A byte arriving with the transfer is judged as if already back in HUNT.
                    if (w_xfer) begin
                        frame_valid <= 1'b0;
                        frame_cnt   <= frame_cnt + 8'd1;
                        if (w_sync) begin
                            r_state <= PAYLOAD;
                            r_idx   <= '0;
                            r_xor   <= '0;
                        end else begin
                            r_state <= HUNT;
                        end
                    end
                end
                default: r_state <= HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Randomized self-checking bench for uart_frame_ctrl against a frame-level reference model.
module tb_uart_frame_ctrl;

    localparam int unsigned TO       = 16;
    localparam logic [7:0]  EV_FRAME = 8'd1;
    localparam logic [7:0]  EV_ERR   = 8'd2;

    logic        clk         = 1'b0;
    logic        rst_n       = 1'b0;
    logic        rx_valid    = 1'b0;
    logic [7:0]  rx_data     = 8'h00;
    logic        rx_perr     = 1'b0;
    logic        frame_ready = 1'b0;
    logic        frame_valid;
    logic [31:0] frame_data;
    logic        err_pulse;
    logic [1:0]  err_code;
    logic [7:0]  frame_cnt;
    logic [7:0]  err_cnt;

    int unsigned n_chk = 0;
    int unsigned n_fail = 0;
    int unsigned cyc = 0;

    // Reference model: bytes of the open frame, the held word and an idle count.
    bit          m_open;
    bit          m_hold;
    logic [7:0]  m_bytes[$];
    logic [31:0] m_word;
    int unsigned m_idle;
    logic [7:0]  e_fcnt;
    logic [7:0]  e_ecnt;

    // Events: {kind, cycle tag, data-or-code}
    logic [63:0] exp_ev[$];
    logic [63:0] obs_ev[$];

    always #5 clk = ~clk;

    uart_frame_ctrl #(
        .TIMEOUT_CYCLES(TO),
        .SYNC_BYTE     (8'hAA)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_perr    (rx_perr),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .frame_data (frame_data),
        .err_pulse  (err_pulse),
        .err_code   (err_code),
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt)
    );

    task automatic model_reset();
        m_open = 1'b0;
        m_hold = 1'b0;
        m_bytes.delete();
        m_word = '0;
        m_idle = 0;
        e_fcnt = '0;
        e_ecnt = '0;
    endtask

    task automatic model_err(input logic [1:0] code);
        m_open = 1'b0;
        exp_ev.push_back({EV_ERR, 24'(cyc), 30'd0, code});
        if (e_ecnt != 8'd255) e_ecnt = e_ecnt + 8'd1;
    endtask

    task automatic model_step(input bit v, input logic [7:0] d, input bit p, input bit r);
        logic [7:0] x;
        bit hunt;
        hunt = 1'b0;
        if (m_hold && r) begin
            exp_ev.push_back({EV_FRAME, 24'(cyc - 1), m_word});
            m_hold = 1'b0;
            e_fcnt = e_fcnt + 8'd1;
            hunt = 1'b1;
        end else if (m_hold) begin
            if (v) model_err(2'd0);
        end else if (m_open) begin
            if (v && p) begin
                model_err(2'd1);
            end else if (v && m_bytes.size() < 4) begin
                m_bytes.push_back(d);
                m_idle = 0;
            end else if (v) begin
                x = 8'h00;
                foreach (m_bytes[i]) x = x ^ m_bytes[i];
                if (d == x) begin
                    m_word = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                    m_hold = 1'b1;
                    m_open = 1'b0;
                end else begin
                    model_err(2'd2);
                end
            end else if (m_idle == TO - 1) begin
                model_err(2'd3);
            end else begin
                m_idle++;
            end
        end else begin
            hunt = 1'b1;
        end
        if (hunt && v && !p && d == 8'hAA) begin
            m_open = 1'b1;
            m_bytes.delete();
            m_idle = 0;
        end
    endtask

    // One clock: record what the DUT shows, apply inputs, advance, update the model.
    task automatic step_cycle(input bit v, input logic [7:0] d, input bit p, input bit r);
        if (err_pulse === 1'b1) obs_ev.push_back({EV_ERR, 24'(cyc), 30'd0, err_code});
        rx_valid    = v;
        rx_data     = d;
        rx_perr     = p;
        frame_ready = r;
        if (frame_valid === 1'b1 && r) obs_ev.push_back({EV_FRAME, 24'(cyc), frame_data});
        @(posedge clk);
        #1;
        cyc++;
        model_step(v, d, p, r);
    endtask

    function automatic bit rdy(input int unsigned mode);
        if (mode == 2) return ($urandom_range(0, 3) != 0);
        return (mode == 1);
    endfunction

    task automatic send_byte(input logic [7:0] d, input bit p, input int unsigned gap,
                             input int unsigned rmode);
        for (int unsigned i = 0; i < gap; i++) step_cycle(1'b0, 8'h00, 1'b0, rdy(rmode));
        step_cycle(1'b1, d, p, rdy(rmode));
    endtask

    // perr_at 0..4 flags that payload/checksum byte with a parity error; 5+ means none.
    task automatic send_frame(input logic [31:0] w, input bit bad, input int unsigned perr_at,
                              input int unsigned gmax, input int unsigned rmode);
        logic [7:0] x;
        x = w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
        send_byte(8'hAA, 1'b0, $urandom_range(0, gmax), rmode);
        for (int unsigned i = 0; i < 4; i++)
            send_byte(w[8*i +: 8], perr_at == i, $urandom_range(0, gmax), rmode);
        send_byte(bad ? (x ^ 8'h01) : x, perr_at == 4, $urandom_range(0, gmax), rmode);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_chk++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset frame_valid: got %b expected 0", frame_valid); end
        n_chk++; if (frame_data !== 32'h0) begin n_fail++; $display("FAIL reset frame_data: got %h expected 0", frame_data); end
        n_chk++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL reset err_pulse: got %b expected 0", err_pulse); end
        n_chk++; if (err_code !== 2'd0) begin n_fail++; $display("FAIL reset err_code: got %0d expected 0", err_code); end
        n_chk++; if (frame_cnt !== 8'd0) begin n_fail++; $display("FAIL reset frame_cnt: got %0d expected 0", frame_cnt); end
        n_chk++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset err_cnt: got %0d expected 0", err_cnt); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_good_frame();
        logic [7:0]  seq[6];
        logic [31:0] got;
        seq = '{8'hAA, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        exp_ev.delete(); obs_ev.delete();
        foreach (seq[i]) step_cycle(1'b1, seq[i], 1'b0, 1'b1);
        repeat (3) step_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        n_chk++; if (obs_ev.size() != exp_ev.size()) begin n_fail++; $display("FAIL good_frame events: got %0d expected %0d", obs_ev.size(), exp_ev.size()); end
        foreach (exp_ev[i]) if (i < obs_ev.size()) begin
            n_chk++; if (obs_ev[i] !== exp_ev[i]) begin n_fail++; $display("FAIL good_frame event %0d: got %h expected %h", i, obs_ev[i], exp_ev[i]); end
        end
        got = (obs_ev.size() == 1) ? obs_ev[0][31:0] : 32'hxxxxxxxx;
        n_chk++; if (got !== 32'h04030201) begin n_fail++; $display("FAIL good_frame data: got %h expected 04030201", got); end
        n_chk++; if (frame_cnt !== 8'd1) begin n_fail++; $display("FAIL good_frame frame_cnt: got %0d expected 1", frame_cnt); end
        n_chk++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL good_frame err_cnt: got %0d expected 0", err_cnt); end
    endtask

    task automatic test_bad_checksum();
        logic [7:0]  seq[6];
        logic [63:0] first;
        seq = '{8'hAA, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        exp_ev.delete(); obs_ev.delete();
        foreach (seq[i]) step_cycle(1'b1, seq[i], 1'b0, 1'b1);
        repeat (3) step_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        first = (obs_ev.size() > 0) ? obs_ev[0] : '0;
        n_chk++; if (obs_ev.size() != 1 || first[63:56] !== EV_ERR || first[1:0] !== 2'd2) begin n_fail++; $display("FAIL bad_csum pulse: got %0d events first %h expected one code-2 error", obs_ev.size(), first); end
        n_chk++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL bad_csum err_cnt: got %0d expected 1", err_cnt); end
        send_frame($urandom, 1'b0, 5, 3, 1);
        repeat (3) step_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        n_chk++; if (obs_ev.size() != exp_ev.size()) begin n_fail++; $display("FAIL bad_csum events: got %0d expected %0d", obs_ev.size(), exp_ev.size()); end
        foreach (exp_ev[i]) if (i < obs_ev.size()) begin
            n_chk++; if (obs_ev[i] !== exp_ev[i]) begin n_fail++; $display("FAIL bad_csum event %0d: got %h expected %h", i, obs_ev[i], exp_ev[i]); end
        end
        n_chk++; if (frame_cnt !== 8'd2) begin n_fail++; $display("FAIL bad_csum frame_cnt: got %0d expected 2", frame_cnt); end
    endtask

    task automatic test_parity_noise();
        logic [63:0] first;
        exp_ev.delete(); obs_ev.delete();
        step_cycle(1'b1, 8'hAA, 1'b1, 1'b1);
        step_cycle(1'b1, 8'h00, 1'b0, 1'b1);
        step_cycle(1'b1, 8'hFF, 1'b0, 1'b1);
        step_cycle(1'b1, 8'h55, 1'b0, 1'b1);
        repeat (3) step_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        n_chk++; if (obs_ev.size() != 0 || err_cnt !== 8'd1) begin n_fail++; $display("FAIL noise quiet: got %0d events err_cnt %0d expected 0 events err_cnt 1", obs_ev.size(), err_cnt); end
        step_cycle(1'b1, 8'hAA, 1'b0, 1'b1);
        step_cycle(1'b1, 8'h11, 1'b1, 1'b1);
        repeat (3) step_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        first = (obs_ev.size() > 0) ? obs_ev[0] : '0;
        n_chk++; if (obs_ev.size() != 1 || first[63:56] !== EV_ERR || first[1:0] !== 2'd1) begin n_fail++; $display("FAIL parity pulse: got %0d events first %h expected one code-1 error", obs_ev.size(), first); end
        n_chk++; if (err_cnt !== 8'd2) begin n_fail++; $display("FAIL parity err_cnt: got %0d expected 2", err_cnt); end
        send_frame($urandom, 1'b0, 5, 2, 1);
        repeat (3) step_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        n_chk++; if (obs_ev.size() != exp_ev.size()) begin n_fail++; $display("FAIL parity events: got %0d expected %0d", obs_ev.size(), exp_ev.size()); end
        foreach (exp_ev[i]) if (i < obs_ev.size()) begin
            n_chk++; if (obs_ev[i] !== exp_ev[i]) begin n_fail++; $display("FAIL parity event %0d: got %h expected %h", i, obs_ev[i], exp_ev[i]); end
        end
    endtask

    task automatic test_timeout();
        int unsigned c01;
        logic [63:0] ev;
        exp_ev.delete(); obs_ev.delete();
        step_cycle(1'b1, 8'hAA, 1'b0, 1'b1);
        step_cycle(1'b1, 8'h01, 1'b0, 1'b1);
        c01 = cyc;
        repeat (TO + 4) step_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        ev = (obs_ev.size() > 0) ? obs_ev[0] : '0;
        n_chk++; if (obs_ev.size() != 1 || ev !== {EV_ERR, 24'(c01 + TO), 32'd3}) begin n_fail++; $display("FAIL timeout pulse: got %0d events first %h expected %h", obs_ev.size(), ev, {EV_ERR, 24'(c01 + TO), 32'd3}); end
        // Every later byte lands exactly in the terminal cycle and must win.
        step_cycle(1'b1, 8'hAA, 1'b0, 1'b1);
        step_cycle(1'b1, 8'h01, 1'b0, 1'b1);
        send_byte(8'h02, 1'b0, TO - 1, 1);
        send_byte(8'h03, 1'b0, TO - 1, 1);
        send_byte(8'h04, 1'b0, TO - 1, 1);
        send_byte(8'h04, 1'b0, TO - 1, 1);
        repeat (3) step_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        ev = (obs_ev.size() > 1) ? obs_ev[1] : '0;
        n_chk++; if (obs_ev.size() != 2 || ev[63:56] !== EV_FRAME || ev[31:0] !== 32'h04030201) begin n_fail++; $display("FAIL timeout terminal byte: got %0d events last %h expected frame 04030201", obs_ev.size(), ev); end
        n_chk++; if (obs_ev.size() != exp_ev.size()) begin n_fail++; $display("FAIL timeout events: got %0d expected %0d", obs_ev.size(), exp_ev.size()); end
        foreach (exp_ev[i]) if (i < obs_ev.size()) begin
            n_chk++; if (obs_ev[i] !== exp_ev[i]) begin n_fail++; $display("FAIL timeout event %0d: got %h expected %h", i, obs_ev[i], exp_ev[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w;
        logic [31:0] w2;
        logic [7:0]  x2;
        int unsigned n_ovr;
        exp_ev.delete(); obs_ev.delete();
        w  = $urandom;
        w2 = $urandom;
        x2 = w2[7:0] ^ w2[15:8] ^ w2[23:16] ^ w2[31:24];
        send_frame(w, 1'b0, 5, 2, 0);
        for (int i = 0; i < 20; i++) begin
            step_cycle(i == 7, 8'h7E, 1'b0, 1'b0);
            n_chk++; if (frame_valid !== 1'b1 || frame_data !== w) begin n_fail++; $display("FAIL hold cycle %0d: got valid %b data %h expected 1 %h", i, frame_valid, frame_data, w); end
        end
        step_cycle(1'b1, 8'hAA, 1'b0, 1'b1);
        for (int unsigned i = 0; i < 4; i++) send_byte(w2[8*i +: 8], 1'b0, $urandom_range(0, 2), 1);
        send_byte(x2, 1'b0, 0, 1);
        repeat (3) step_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        n_ovr = 0;
        foreach (obs_ev[i]) if (obs_ev[i][63:56] == EV_ERR && obs_ev[i][1:0] == 2'd0) n_ovr++;
        n_chk++; if (n_ovr != 1) begin n_fail++; $display("FAIL overrun pulses: got %0d expected 1", n_ovr); end
        n_chk++; if (obs_ev.size() != exp_ev.size()) begin n_fail++; $display("FAIL backpressure events: got %0d expected %0d", obs_ev.size(), exp_ev.size()); end
        foreach (exp_ev[i]) if (i < obs_ev.size()) begin
            n_chk++; if (obs_ev[i] !== exp_ev[i]) begin n_fail++; $display("FAIL backpressure event %0d: got %h expected %h", i, obs_ev[i], exp_ev[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int unsigned kind;
        exp_ev.delete(); obs_ev.delete();
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 7);
            if (kind == 7) send_byte(8'(($urandom_range(0, 254) + 8'hAB)), 1'b0, 0, 2);
            send_frame($urandom, kind == 5, (kind == 6) ? $urandom_range(0, 4) : 5, (n < 20) ? 0 : 3, (n < 20) ? 1 : 2);
        end
        repeat (TO + 4) step_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        n_chk++; if (obs_ev.size() != exp_ev.size()) begin n_fail++; $display("FAIL stream events: got %0d expected %0d", obs_ev.size(), exp_ev.size()); end
        foreach (exp_ev[i]) if (i < obs_ev.size()) begin
            n_chk++; if (obs_ev[i] !== exp_ev[i]) begin n_fail++; $display("FAIL stream event %0d: got %h expected %h", i, obs_ev[i], exp_ev[i]); end
        end
        n_chk++; if (frame_cnt !== e_fcnt || err_cnt !== e_ecnt) begin n_fail++; $display("FAIL stream counters: got %0d/%0d expected %0d/%0d", frame_cnt, err_cnt, e_fcnt, e_ecnt); end
    endtask

    task automatic test_counters();
        logic [7:0] start;
        exp_ev.delete(); obs_ev.delete();
        start = e_fcnt;
        for (int n = 0; n < 256; n++) send_frame($urandom, 1'b0, 5, 0, 1);
        repeat (3) step_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        n_chk++; if (frame_cnt !== start) begin n_fail++; $display("FAIL frame_cnt wrap: got %0d expected %0d", frame_cnt, start); end
        send_frame($urandom, 1'b0, 5, 0, 0);
        for (int n = 0; n < 300; n++) step_cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        step_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        n_chk++; if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL err_cnt saturate: got %0d expected 255", err_cnt); end
        repeat (3) step_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        n_chk++; if (obs_ev.size() != exp_ev.size()) begin n_fail++; $display("FAIL counters events: got %0d expected %0d", obs_ev.size(), exp_ev.size()); end
        foreach (exp_ev[i]) if (i < obs_ev.size()) begin
            n_chk++; if (obs_ev[i] !== exp_ev[i]) begin n_fail++; $display("FAIL counters event %0d: got %h expected %h", i, obs_ev[i], exp_ev[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        logic [31:0] got;
        step_cycle(1'b1, 8'hAA, 1'b0, 1'b1);
        step_cycle(1'b1, 8'h01, 1'b0, 1'b1);
        step_cycle(1'b1, 8'h02, 1'b0, 1'b1);
        rx_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        n_chk++; if ({frame_valid, err_pulse, err_code, frame_cnt, err_cnt, frame_data} !== '0) begin n_fail++; $display("FAIL mid reset outputs: got valid %b pulse %b code %0d fcnt %0d ecnt %0d data %h expected all 0", frame_valid, err_pulse, err_code, frame_cnt, err_cnt, frame_data); end
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
        model_reset();
        exp_ev.delete(); obs_ev.delete();
        w = $urandom;
        send_frame(w, 1'b0, 5, 2, 1);
        repeat (3) step_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        got = (obs_ev.size() == 1) ? obs_ev[0][31:0] : 32'hxxxxxxxx;
        n_chk++; if (got !== w) begin n_fail++; $display("FAIL after reset frame: got %h expected %h", got, w); end
        n_chk++; if (frame_cnt !== 8'd1 || err_cnt !== 8'd0) begin n_fail++; $display("FAIL after reset counters: got %0d/%0d expected 1/0", frame_cnt, err_cnt); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_parity_noise();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_counters();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
